// File: rtl/input_conditioner_pkg.sv
// incond_pkg: debounce FSM state encoding and default parameters for input_conditioner.
package incond_pkg;
    typedef enum logic [1:0] {
        S_LOW  = 2'd0,
        S_RISE = 2'd1,
        S_HIGH = 2'd2,
        S_FALL = 2'd3
    } state_t;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_DB_CYCLES   = 4;
    localparam int DEF_CNT_W       = 4;
endpackage

// File: rtl/input_conditioner_if.sv
// input_conditioner_if: raw input and conditioned outputs of input_conditioner.
// Optional INCOND_FALL_PULSE_EN adds the X_FALL falling-edge pulse.
interface input_conditioner_if;
    logic RAW_IN;
    logic X_PULSE;
    logic X_LEVEL;
    logic BUSY;
`ifdef INCOND_FALL_PULSE_EN
    logic X_FALL;
`endif
    modport master (
        output RAW_IN,
`ifdef INCOND_FALL_PULSE_EN
        input  X_FALL,
`endif
        input  X_PULSE, X_LEVEL, BUSY
    );
    modport slave (
        input  RAW_IN,
`ifdef INCOND_FALL_PULSE_EN
        output X_FALL,
`endif
        output X_PULSE, X_LEVEL, BUSY
    );
endinterface

// File: rtl/input_conditioner_sync_chain.sv
// sync_chain: STAGES-deep synchroniser shift chain with synchronous active-low clear.
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic CLK,
    input  logic nRST,
    input  logic i_d,
    output logic o_q
);
    logic [STAGES-1:0] r_sh;
    always_ff @(posedge CLK) begin
        if (!nRST) r_sh <= '0;
        else       r_sh <= {r_sh[STAGES-2:0], i_d};
    end
    assign o_q = r_sh[STAGES-1];
endmodule

// File: rtl/input_conditioner.sv
// input_conditioner: synchronise and debounce RAW_IN into a one-cycle X_PULSE and clean X_LEVEL.
// Optional INCOND_FALL_PULSE_EN adds X_FALL, pulsing when the debounced level falls.
module input_conditioner
    import incond_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int DB_CYCLES   = DEF_DB_CYCLES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input logic                CLK,
    input logic                nRST,
    input_conditioner_if.slave bus
);
    state_t             r_state, w_state;
    logic [CNT_W-1:0]   r_cnt, w_cnt;
    logic               r_level, w_level;
    logic               r_pulse, w_pulse;
    logic               r_busy;
    logic               w_sync;
    logic               w_last;

    sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
        .CLK  (CLK),
        .nRST (nRST),
        .i_d  (bus.RAW_IN),
        .o_q  (w_sync)
    );

    assign w_last = r_cnt == CNT_W'(DB_CYCLES - 1);

    // Counter restarts on any disagreeing sample and rests at 0 in the stable states.
    always_comb begin
        w_state = r_state;
        w_cnt   = '0;
        w_level = r_level;
        w_pulse = 1'b0;
        case (r_state)
            S_LOW: begin
                w_state = w_sync ? S_RISE : S_LOW;
                w_cnt   = w_sync ? CNT_W'(1) : '0;
            end
            S_RISE: begin
                w_state = !w_sync ? S_LOW : (w_last ? S_HIGH : S_RISE);
                w_cnt   = (w_sync && !w_last) ? r_cnt + CNT_W'(1) : '0;
                w_level = w_sync && w_last ? 1'b1 : r_level;
                w_pulse = w_sync && w_last;
            end
            S_HIGH: begin
                w_state = !w_sync ? S_FALL : S_HIGH;
                w_cnt   = !w_sync ? CNT_W'(1) : '0;
            end
            S_FALL: begin
                w_state = w_sync ? S_HIGH : (w_last ? S_LOW : S_FALL);
                w_cnt   = (!w_sync && !w_last) ? r_cnt + CNT_W'(1) : '0;
                w_level = !w_sync && w_last ? 1'b0 : r_level;
            end
            default: begin
                w_state = S_LOW;
                w_level = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state <= S_LOW;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_pulse <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_level <= w_level;
            r_pulse <= w_pulse;
            r_busy  <= (w_state == S_RISE) || (w_state == S_FALL);
        end
    end

    assign bus.X_PULSE = r_pulse;
    assign bus.X_LEVEL = r_level;
    assign bus.BUSY    = r_busy;

`ifdef INCOND_FALL_PULSE_EN
    logic r_fall;
    always_ff @(posedge CLK) begin
        if (!nRST) r_fall <= 1'b0;
        else       r_fall <= (r_state == S_FALL) && !w_sync && w_last;
    end
    assign bus.X_FALL = r_fall;
`endif
endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: directed checks of reset, rise, glitch, bounce, fall and mid-qualification reset.
// Also checks X_FALL when INCOND_FALL_PULSE_EN is defined.
module tb_input_conditioner;
    logic CLK = 1'b0;
    logic nRST;
    int   n_chk = 0;
    int   n_err = 0;

    input_conditioner_if bus ();

    input_conditioner dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Posedges k0..k1 counted from the last RAW_IN change; pa = pulse step, lc = level change step.
    task automatic seq(input int k0, input int k1, input int pa, input int lc,
                       input logic l0, input int blo, input int bhi);
        for (int k = k0; k <= k1; k++) begin
            @(posedge CLK);
            #1;
            chk($sformatf("pulse@%0d", k), bus.X_PULSE, k == pa);
            chk($sformatf("level@%0d", k), bus.X_LEVEL, (lc != 0 && k >= lc) ? ~l0 : l0);
            chk($sformatf("busy@%0d", k), bus.BUSY, blo != 0 && k >= blo && k <= bhi);
`ifdef INCOND_FALL_PULSE_EN
            chk($sformatf("fall@%0d", k), bus.X_FALL, lc != 0 && k == lc && l0);
`endif
        end
    endtask

    initial begin
        nRST       = 1'b0;
        bus.RAW_IN = 1'b1;
        seq(1, 2, 0, 0, 1'b0, 0, 0);
        nRST = 1'b1;
        seq(1, 7, 6, 6, 1'b0, 3, 5);
        bus.RAW_IN = 1'b0;
        seq(1, 7, 0, 6, 1'b1, 3, 5);
        bus.RAW_IN = 1'b1;
        seq(1, 2, 0, 0, 1'b0, 0, 0);
        bus.RAW_IN = 1'b0;
        seq(3, 8, 0, 0, 1'b0, 3, 4);
        bus.RAW_IN = 1'b1;
        seq(1, 1, 0, 0, 1'b0, 0, 0);
        bus.RAW_IN = 1'b0;
        seq(2, 2, 0, 0, 1'b0, 0, 0);
        bus.RAW_IN = 1'b1;
        seq(3, 3, 0, 0, 1'b0, 3, 3);
        bus.RAW_IN = 1'b0;
        seq(4, 4, 0, 0, 1'b0, 0, 0);
        bus.RAW_IN = 1'b1;
        seq(5, 5, 0, 0, 1'b0, 5, 5);
        seq(6, 12, 10, 10, 1'b0, 7, 9);
        bus.RAW_IN = 1'b0;
        seq(1, 7, 0, 6, 1'b1, 3, 5);
        bus.RAW_IN = 1'b1;
        seq(1, 4, 0, 0, 1'b0, 3, 4);
        nRST       = 1'b0;
        bus.RAW_IN = 1'b0;
        seq(1, 1, 0, 0, 1'b0, 0, 0);
        nRST = 1'b1;
        seq(1, 8, 0, 0, 1'b0, 0, 0);
        bus.RAW_IN = 1'b1;
        seq(1, 7, 6, 6, 1'b0, 3, 5);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
